// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the parametrised SPI master.
//   - FSM state encoding (IDLE, SEND, HOLD, DONE).
//   - SPI mode constants expressed as {CPOL, CPHA} pairs.
package spi_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SCLK generator for spi_master_param.
// A half-period divider produces one SCLK toggle ("edge") every CLK_DIV/2
// cycles while enabled; an edge counter tags each edge as leading (even) or
// trailing (odd) and flags the final edge of the word. Everything clears
// whenever en is low, so SCLK rests at CPOL outside a transfer.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   en           high only while the master is shifting
//   sclk         registered serial clock
//   lead_pulse   one-cycle strobe: this cycle's clock edge is a leading edge
//   trail_pulse  one-cycle strobe: this cycle's clock edge is a trailing edge
//   last_edge    one-cycle strobe: this cycle's clock edge is edge 2*DATA_W-1
module spi_sclk_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int CPOL    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic lead_pulse,
  output logic trail_pulse,
  output logic last_edge
);

  localparam int H      = CLK_DIV / 2;
  localparam int DIV_W  = (H > 1) ? $clog2(H) : 1;
  localparam int EDGE_W = (2 * DATA_W > 1) ? $clog2(2 * DATA_W) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(H - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              tick;

  // tick marks the cycle whose closing clk edge toggles SCLK
  assign tick        = en && (div_cnt == DIV_LAST);
  assign lead_pulse  = tick && !edge_cnt[0];
  assign trail_pulse = tick &&  edge_cnt[0];
  assign last_edge   = tick && (edge_cnt == EDGE_LAST);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= 1'(CPOL);
    end else if (tick) begin
      div_cnt  <= '0;
      sclk     <= ~sclk;
      edge_cnt <= (edge_cnt == EDGE_LAST) ? '0 : edge_cnt + 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: full-duplex SPI master with SPI_EN/SPI_FIN four-phase
// handshake. Word width, SCLK divider, SPI mode, bit order and CS hold time
// are parameters. MISO is captured in the same bit order as MOSI is sent.
// Ports:
//   CLK        system clock (posedge)
//   RST        synchronous active-high reset; abandons any transfer
//   SPI_EN     transfer request, held until SPI_FIN is seen
//   SPI_DATA   transmit word, sampled every cycle while idle
//   SPI_RDATA  received word, updated on completion, valid while SPI_FIN=1
//   SDI / SDO  MISO input / MOSI output (SDO idles high)
//   SCLK       registered serial clock, idles at CPOL
//   CS         active-low chip select (combinational)
//   SPI_FIN    transfer complete
//   BUSY       high whenever not idle
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int CPOL      = 1,
  parameter int CPHA      = 1,
  parameter int LSB_FIRST = 0,
  parameter int HOLD_CYC  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SPI_EN,
  input  logic [DATA_W-1:0] SPI_DATA,
  output logic [DATA_W-1:0] SPI_RDATA,
  input  logic              SDI,
  output logic              SDO,
  output logic              SCLK,
  output logic              CS,
  output logic              SPI_FIN,
  output logic              BUSY
);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || DATA_W < 1 || DATA_W > 32) begin : g_bad_params
    $fatal(1, "spi_master_param: CLK_DIV must be even and >= 2, DATA_W must be 1..32");
  end

  localparam int HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  logic [1:0]        state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [DATA_W-1:0] rx_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic              lead_pulse;
  logic              trail_pulse;
  logic              last_edge;
  logic              shift_edge;
  logic              sample_edge;

  // Bit that goes on the wire next.
  function automatic logic tx_bit(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
  endfunction

  // Move the transmit word one position toward the output end.
  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  // Insert a received bit so the final word has the same bit order as transmit.
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v, input logic b);
    logic [DATA_W-1:0] t;
    if (LSB_FIRST != 0) begin
      t = v >> 1;
      t[DATA_W-1] = b;
    end else begin
      t = v << 1;
      t[0] = b;
    end
    return t;
  endfunction

  spi_sclk_gen #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV),
    .CPOL   (CPOL)
  ) u_sclk_gen (
    .clk        (CLK),
    .rst        (RST),
    .en         (state == SEND),
    .sclk       (SCLK),
    .lead_pulse (lead_pulse),
    .trail_pulse(trail_pulse),
    .last_edge  (last_edge)
  );

  // CPHA=0 presents bit 0 before the first edge, so it never shifts on the
  // closing trailing edge; CPHA=1 shifts on every leading edge instead.
  assign shift_edge  = (CPHA != 0) ? lead_pulse : (trail_pulse && !last_edge);
  assign sample_edge = (CPHA != 0) ? trail_pulse : lead_pulse;

  assign CS   = (state == IDLE) && !SPI_EN;
  assign BUSY = (state != IDLE);

  always_comb begin
    rx_next = sample_edge ? rx_shift(rx_reg, SDI) : rx_reg;
  end

  // Control: FSM, SDO, completion flag and received-word register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      SDO       <= 1'b1;
      SPI_RDATA <= '0;
      hold_cnt  <= '0;
      SPI_FIN   <= 1'b0;
    end else begin
      SPI_FIN <= (state == DONE);
      case (state)
        IDLE: begin
          SDO      <= 1'b1;
          hold_cnt <= '0;
          if (SPI_EN) begin
            state <= SEND;
            if (CPHA == 0) SDO <= tx_bit(SPI_DATA);
          end
        end
        SEND: begin
          if (shift_edge) SDO <= tx_bit(shift_reg);
          if (last_edge) begin
            if (HOLD_CYC == 0) begin
              state     <= DONE;
              SPI_RDATA <= rx_next;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= DONE;
            SPI_RDATA <= rx_reg;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!SPI_EN) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: transmit and receive shift registers. For CPHA=0 the first bit is
  // already on SDO when SEND starts, so the word is loaded pre-shifted.
  always_ff @(posedge CLK) begin
    case (state)
      IDLE: begin
        shift_reg <= (CPHA == 0 && SPI_EN) ? tx_shift(SPI_DATA) : SPI_DATA;
        rx_reg    <= '0;
      end
      SEND: begin
        if (shift_edge) shift_reg <= tx_shift(shift_reg);
        rx_reg <= rx_next;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: four differently parametrised masters on one clock.
// A negedge monitor records, per instance, the SDO and SDI values seen at
// each SCLK sampling edge; transfers are then judged against the transmitted
// word, the recorded SDI bits, and the latency formula.
module tb_spi_master_param;

  localparam int NI = 4;
  localparam int CW   [NI] = '{8, 16, 5, 12};
  localparam int DIV  [NI] = '{4, 2, 6, 2};
  localparam int POL  [NI] = '{1, 0, 0, 1};
  localparam int PHA  [NI] = '{1, 0, 1, 0};
  localparam int LSBF [NI] = '{0, 1, 0, 1};
  localparam int HOLD [NI] = '{4, 4, 0, 1};

  logic        clk;
  logic        rst;
  logic        en      [NI];
  logic [31:0] data    [NI];
  logic        sdi     [NI];
  logic        sdo     [NI];
  logic        sclk    [NI];
  logic        cs      [NI];
  logic        fin     [NI];
  logic        busy    [NI];
  logic [31:0] rdata   [NI];
  logic [7:0]  rd0;
  logic [15:0] rd1;
  logic [4:0]  rd2;
  logic [11:0] rd3;

  logic        sdi_loop [NI];
  logic        sdi_rand [NI];
  logic        sdi_fix  [NI];
  logic        rnd      [NI];
  logic        psclk    [NI];
  logic        psdo     [NI];
  logic        psdi     [NI];
  int          edges    [NI];
  int          viol     [NI];
  logic        sdo_q    [NI][$];
  logic        sdi_q    [NI][$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .HOLD_CYC(4)) u_dut0 (
    .CLK(clk), .RST(rst), .SPI_EN(en[0]), .SPI_DATA(data[0][7:0]), .SPI_RDATA(rd0), .SDI(sdi[0]),
    .SDO(sdo[0]), .SCLK(sclk[0]), .CS(cs[0]), .SPI_FIN(fin[0]), .BUSY(busy[0]));
  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .CPOL(0), .CPHA(0), .LSB_FIRST(1), .HOLD_CYC(4)) u_dut1 (
    .CLK(clk), .RST(rst), .SPI_EN(en[1]), .SPI_DATA(data[1][15:0]), .SPI_RDATA(rd1), .SDI(sdi[1]),
    .SDO(sdo[1]), .SCLK(sclk[1]), .CS(cs[1]), .SPI_FIN(fin[1]), .BUSY(busy[1]));
  spi_master_param #(.DATA_W(5), .CLK_DIV(6), .CPOL(0), .CPHA(1), .LSB_FIRST(0), .HOLD_CYC(0)) u_dut2 (
    .CLK(clk), .RST(rst), .SPI_EN(en[2]), .SPI_DATA(data[2][4:0]), .SPI_RDATA(rd2), .SDI(sdi[2]),
    .SDO(sdo[2]), .SCLK(sclk[2]), .CS(cs[2]), .SPI_FIN(fin[2]), .BUSY(busy[2]));
  spi_master_param #(.DATA_W(12), .CLK_DIV(2), .CPOL(1), .CPHA(0), .LSB_FIRST(1), .HOLD_CYC(1)) u_dut3 (
    .CLK(clk), .RST(rst), .SPI_EN(en[3]), .SPI_DATA(data[3][11:0]), .SPI_RDATA(rd3), .SDI(sdi[3]),
    .SDO(sdo[3]), .SCLK(sclk[3]), .CS(cs[3]), .SPI_FIN(fin[3]), .BUSY(busy[3]));

  assign rdata[0] = {24'd0, rd0};
  assign rdata[1] = {16'd0, rd1};
  assign rdata[2] = {27'd0, rd2};
  assign rdata[3] = {20'd0, rd3};

  always_comb begin
    for (int k = 0; k < NI; k++)
      sdi[k] = sdi_loop[k] ? sdo[k] : (sdi_rand[k] ? rnd[k] : sdi_fix[k]);
  end

  // Sampling edge: rising when CPOL==CPHA, falling otherwise. SDI recorded is
  // the value present just before the clk edge that produced the SCLK edge.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (sclk[k] !== psclk[k]) begin
        edges[k]++;
        if ((sclk[k] == 1'b1) == (POL[k] == PHA[k])) begin
          sdo_q[k].push_back(sdo[k]);
          sdi_q[k].push_back(psdi[k]);
          if (sdo[k] !== psdo[k]) viol[k]++;
        end
      end
      psclk[k] = sclk[k];
      psdo[k]  = sdo[k];
      rnd[k]   = 1'($urandom_range(0, 1));
      psdi[k]  = sdi_loop[k] ? sdo[k] : (sdi_rand[k] ? rnd[k] : sdi_fix[k]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete handshake on instance k. extra = cycles SPI_EN stays high
  // after SPI_FIN is seen; b2b leaves right after DONE->IDLE so the next call
  // re-raises SPI_EN after exactly one low cycle.
  task automatic do_xfer(input int k, input logic [31:0] word, input int extra, input bit b2b);
    int          lat_exp;
    int          lat;
    int          cyc;
    int          bad_cs;
    int          bad_busy;
    int          bad_fin;
    int          e0;
    int          v0;
    int          q0;
    int          n;
    logic [31:0] mask;
    logic [31:0] obs_tx;
    logic [31:0] obs_rx;
    lat_exp = 1 + CW[k] * DIV[k] + HOLD[k];
    mask = (CW[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << CW[k]) - 32'd1);
    @(negedge clk);
    chk($sformatf("k%0d_sclk_idle", k), 32'(sclk[k]), 32'(POL[k]));
    e0 = edges[k];
    v0 = viol[k];
    q0 = sdo_q[k].size();
    data[k] = word;
    en[k] = 1'b1;
    #1 chk($sformatf("k%0d_cs_fall", k), 32'(cs[k]), 32'd0);
    @(posedge clk);
    #1 chk($sformatf("k%0d_busy_start", k), 32'(busy[k]), 32'd1);
    cyc = 0; lat = -1; bad_cs = 0; bad_busy = 0;
    while (lat < 0 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cs[k] !== 1'b0) bad_cs++;
      if (busy[k] !== 1'b1) bad_busy++;
      if (fin[k] === 1'b1) lat = cyc;
    end
    chk($sformatf("k%0d_latency", k), 32'(lat), 32'(lat_exp));
    chk($sformatf("k%0d_cs_low", k), 32'(bad_cs), 32'd0);
    chk($sformatf("k%0d_busy_run", k), 32'(bad_busy), 32'd0);
    bad_fin = 0;
    for (int i = 0; i < extra; i++) begin
      @(posedge clk);
      #1 if (fin[k] !== 1'b1) bad_fin++;
    end
    chk($sformatf("k%0d_fin_hold", k), 32'(bad_fin), 32'd0);
    @(negedge clk);
    en[k] = 1'b0;
    #1 chk($sformatf("k%0d_cs_done", k), 32'(cs[k]), 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("k%0d_idle", k), 32'(busy[k]), 32'd0);
    chk($sformatf("k%0d_cs_rise", k), 32'(cs[k]), 32'd1);
    chk($sformatf("k%0d_sclk_end", k), 32'(sclk[k]), 32'(POL[k]));
    n = sdo_q[k].size() - q0;
    chk($sformatf("k%0d_edges", k), 32'(edges[k] - e0), 32'(2 * CW[k]));
    chk($sformatf("k%0d_samples", k), 32'(n), 32'(CW[k]));
    chk($sformatf("k%0d_sdo_phase", k), 32'(viol[k] - v0), 32'd0);
    obs_tx = '0;
    obs_rx = '0;
    for (int i = 0; i < n && i < CW[k]; i++) begin
      if (LSBF[k] != 0) begin
        obs_tx[i] = sdo_q[k][q0 + i];
        obs_rx[i] = sdi_q[k][q0 + i];
      end else begin
        obs_tx[CW[k] - 1 - i] = sdo_q[k][q0 + i];
        obs_rx[CW[k] - 1 - i] = sdi_q[k][q0 + i];
      end
    end
    chk($sformatf("k%0d_sdo_word", k), obs_tx, word & mask);
    chk($sformatf("k%0d_rdata", k), rdata[k], obs_rx);
    if (!b2b) begin
      @(posedge clk);
      #1;
      chk($sformatf("k%0d_fin_drop", k), 32'(fin[k]), 32'd0);
      chk($sformatf("k%0d_sdo_idle", k), 32'(sdo[k]), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] w;
    clk = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      en[k] = 1'b0; data[k] = '0; sdi_loop[k] = 1'b0; sdi_rand[k] = 1'b1; sdi_fix[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("k%0d_rst_busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("k%0d_rst_fin", k), 32'(fin[k]), 32'd0);
      chk($sformatf("k%0d_rst_sdo", k), 32'(sdo[k]), 32'd1);
      chk($sformatf("k%0d_rst_sclk", k), 32'(sclk[k]), 32'(POL[k]));
      chk($sformatf("k%0d_rst_rdata", k), rdata[k], 32'd0);
      chk($sformatf("k%0d_rst_cs", k), 32'(cs[k]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    // Mode 3 loopback of 0xA5
    sdi_loop[0] = 1'b1;
    do_xfer(0, 32'hA5, 0, 1'b0);
    chk("a5_rdata", rdata[0], 32'hA5);

    // Mode 0, LSB first, 16 bits, SDI tied high
    sdi_rand[1] = 1'b0;
    sdi_fix[1]  = 1'b1;
    do_xfer(1, 32'h8001, 0, 1'b0);
    chk("ffff_rdata", rdata[1], 32'hFFFF);

    // No CS hold time
    do_xfer(2, $urandom, 0, 1'b0);

    // SPI_EN held five extra cycles in DONE
    do_xfer(0, $urandom, 5, 1'b0);

    // Back-to-back with a single low cycle of SPI_EN
    do_xfer(0, 32'h3C, 0, 1'b1);
    chk("b2b_first", rdata[0], 32'h3C);
    do_xfer(0, 32'hC3, 0, 1'b0);
    chk("b2b_second", rdata[0], 32'hC3);

    // Reset ten cycles into SEND, then a clean transfer
    @(negedge clk);
    data[0] = 32'h5A;
    en[0] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_idle", 32'(busy[0]), 32'd0);
    chk("midrst_sclk", 32'(sclk[0]), 32'd1);
    chk("midrst_sdo", 32'(sdo[0]), 32'd1);
    chk("midrst_fin", 32'(fin[0]), 32'd0);
    chk("midrst_rdata", rdata[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en[0] = 1'b0;
    w = $urandom;
    do_xfer(0, w, 0, 1'b0);
    chk("postrst_rdata", rdata[0], w & 32'hFF);

    // Randomised transfers on every configuration
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NI; k++) begin
        sdi_loop[k] = 1'($urandom_range(0, 1));
        sdi_rand[k] = 1'b1;
        do_xfer(k, $urandom, int'($urandom_range(0, 3)), 1'b0);
        do_xfer(k, $urandom, int'($urandom_range(0, 2)), 1'b1);
        do_xfer(k, $urandom, 0, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
